ok_pipe_out_buf: RTL and testbench
==================================

# ok_pipe_out_buf

Buffered pipe-out endpoint that sits directly upstream of the endpoint-to-host wire-OR combiner. User logic pushes 32-bit words into an internal FIFO. The host pops them one per read strobe through a registered 65-bit okEH slice. The slice is all-zero whenever this endpoint is not addressed, so it is safe to OR with other endpoints.

## Interface
Parameters:
- ADDR, 8'hA0, endpoint address this block responds to.
- DEPTH, 16, FIFO depth in words; power of two, 4..1024.
- AW, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- okClk  in  1  single clock for all logic.
- okRst_n  in  1  synchronous, active-low reset, sampled on rising okClk.
- hi_addr  in  8  host-selected endpoint address.
- hi_read  in  1  one-cycle host pop strobe; qualified by hi_addr==ADDR.
- hi_clear  in  1  one-cycle status-clear strobe; qualified by hi_addr==ADDR.
- ep_write  in  1  user push strobe.
- ep_datain  in  32  user push data.
- ep_full  out  1  FIFO holds DEPTH words.
- ep_count  out  AW+1  current occupancy, 0..DEPTH.
- okEH  out  65  slice fed to the wire-OR.

## Operation
- FIFO storage:
  - DEPTH x 32 array with AW-bit read and write pointers that wrap modulo DEPTH.
  - Separate (AW+1)-bit occupancy counter; ep_full = (count==DEPTH).
- sel = (hi_addr==ADDR).
- Pop accepted when sel & hi_read & count!=0.
- Push accepted when ep_write & (count<DEPTH | pop accepted same cycle).
- Push into a full FIFO with no same-cycle pop:
  - Word is dropped; pointers and count are unchanged.
  - Sets the overflow flag.
- Pop request (sel & hi_read) while count==0:
  - No data is returned; okEH[32] stays 0.
  - Sets the underflow flag.
  - A same-cycle push is still accepted; there is no fall-through.
- Simultaneous accepted push and pop: count unchanged; both pointers advance.
- okEH layout, registered:
  - [31:0] popped data; nonzero only in the rd_valid cycle.
  - [32] rd_valid.
  - [33] ready = sel & count!=0.
  - [44:34] zero-extended count when sel, else 0.
  - [46:45] status (see Configuration).
  - [64:47] always 0.
- When sel is 0 and no read is completing, okEH == 65'h0.
- Output state machine: IDLE -> DATA on accepted pop; DATA -> DATA on back-to-back pop; otherwise DATA -> IDLE. DATA drives rd_valid=1.

## Timing
- Reset (okRst_n=0 at a rising edge):
  - Pointers, count and flags go to 0; state goes to IDLE.
  - okEH=0, ep_full=0, ep_count=0 on the following cycle.
- Reset mid-transfer discards all buffered words and any pending rd_valid. A push or pop coincident with reset is ignored.
- Pop latency: pop accepted at edge N -> okEH[31:0]=word and okEH[32]=1 for exactly the cycle after edge N+1.
- Sustained throughput: one word per cycle with continuous hi_read.
- ep_count and ep_full are registered; they reflect all pushes and pops at edge N from cycle N+1.
- A pushed word is poppable no earlier than the edge after its push.
- okEH[33] and okEH[44:34] are registered from sel and count, so they lag hi_addr by one cycle.

## Configuration
- Macro: OK_PIPEOUT_STATUS_EN.
- Defined:
  - Sticky overflow flag drives okEH[45]; sticky underflow flag drives okEH[46]. Both are gated by registered sel.
  - sel & hi_clear clears both flags the next cycle. A same-cycle set event wins over the clear.
- Undefined:
  - Flag registers are not built; okEH[46:45] are tied to 0 and hi_clear is ignored.
  - All FIFO behaviour is otherwise identical.

## Test plan
- Reset: hold okRst_n=0 for 3 cycles with random inputs -> okEH==0, ep_count==0, ep_full==0 on every cycle after the first reset edge.
- Ordering: push 0x11111111, 0x22222222, 0x33333333, then pop 3 back-to-back with hi_addr=8'hA0 -> okEH[31:0] returns the words in order on consecutive cycles with okEH[32]=1; ep_count goes 3,2,1,0.
- Full: DEPTH=16; push 17 words 0..16 -> ep_full=1 after the 16th push; word 16 dropped; 16 pops return 0..15. With macro defined, okEH[45]=1 until hi_clear.
- Full boundary: at full, assert push 0xAAAA5555 and pop in the same cycle -> both accepted; count stays 16; 0xAAAA5555 is the last word popped.
- Underflow and isolation:
  - Pop while empty -> okEH[32]=0, okEH[46]=1 (macro) or 0 (no macro).
  - hi_addr=8'hA1 with hi_read while non-empty -> okEH==0 and count unchanged.
- Mid-operation reset: push 5 words, assert pop, pull okRst_n low on the next edge -> no rd_valid afterwards; ep_count=0; a new push/pop returns only new data.

Source files
------------

// File: rtl/ok_pipe_out_buf_if.sv
// Host/user signal bundle for the buffered pipe-out endpoint.
// master = host + user logic side, slave = the endpoint itself.
interface ok_pipe_out_buf_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  hi_addr;
    logic        hi_read;
    logic        hi_clear;
    logic        ep_write;
    logic [31:0] ep_datain;
    logic        ep_full;
    logic [AW:0] ep_count;
    logic [64:0] okEH;

    modport master (
        output hi_addr, hi_read, hi_clear, ep_write, ep_datain,
        input  ep_full, ep_count, okEH
    );

    modport slave (
        input  hi_addr, hi_read, hi_clear, ep_write, ep_datain,
        output ep_full, ep_count, okEH
    );
endinterface

// File: rtl/ok_pipe_out_buf.sv
// Buffered pipe-out endpoint: user pushes into a FIFO, host pops through a registered okEH slice.
// Optional sticky overflow/underflow status bits enabled by defining OK_PIPEOUT_STATUS_EN.
module ok_pipe_out_buf #(
    parameter logic [7:0] ADDR  = 8'hA0,
    parameter int         DEPTH = 16,
    localparam int        AW    = $clog2(DEPTH)
) (
    input  logic               okClk,
    input  logic               okRst_n,
    ok_pipe_out_buf_if.slave   bus
);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   rd_data;
    logic [64:0]   eh_q;
    logic [64:0]   eh_d;
    state_t        state_q;
    state_t        state_d;
    logic          rd_valid;

    logic sel;
    logic empty;
    logic pop_req;
    logic pop_acc;
    logic push_acc;
    logic ovf_evt;
    logic unf_evt;

    assign sel      = (bus.hi_addr == ADDR);
    assign empty    = (count == '0);
    assign pop_req  = sel & bus.hi_read;
    assign pop_acc  = pop_req & ~empty;
    // A full FIFO still takes a push when a pop frees a slot on the same edge.
    assign push_acc = bus.ep_write & ((count != FULL_CNT) | pop_acc);
    assign ovf_evt  = bus.ep_write & ~push_acc;
    assign unf_evt  = pop_req & empty;

    // NOTE: the storage array has no reset; pointers and count define which words are valid.
    always_ff @(posedge okClk) begin
        if (okRst_n && push_acc) begin
            mem[wr_ptr] <= bus.ep_datain;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge okClk) begin
        if (!okRst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
            state_q <= IDLE;
            eh_q    <= '0;
        end else begin
            state_q <= state_d;
            eh_q    <= eh_d;
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({push_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
    always_comb begin
        state_d  = IDLE;
        rd_valid = (state_q == DATA);
        case (state_q)
            IDLE:    if (pop_acc) state_d = DATA;
            DATA:    if (pop_acc) state_d = DATA;
            default: state_d = IDLE;
        endcase
    end

`ifdef OK_PIPEOUT_STATUS_EN
    logic ovf_q;
    logic unf_q;

    // A set event on the same edge as a clear takes priority.
    always_ff @(posedge okClk) begin
        if (!okRst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_evt)                   ovf_q <= 1'b1;
            else if (sel && bus.hi_clear)  ovf_q <= 1'b0;
            if (unf_evt)                   unf_q <= 1'b1;
            else if (sel && bus.hi_clear)  unf_q <= 1'b0;
        end
    end

    logic [1:0] status;
    assign status = {sel & unf_q, sel & ovf_q};
`else
    logic [1:0] status;
    logic       unused_status;
    assign status        = 2'b00;
    assign unused_status = &{1'b0, bus.hi_clear, ovf_evt, unf_evt};
`endif

    always_comb begin
        eh_d        = '0;
        eh_d[31:0]  = rd_valid ? rd_data : 32'h0;
        eh_d[32]    = rd_valid;
        eh_d[33]    = sel & ~empty;
        eh_d[44:34] = sel ? 11'(count) : 11'h0;
        eh_d[46:45] = status;
    end

    assign bus.okEH     = eh_q;
    assign bus.ep_count = count;
    assign bus.ep_full  = (count == FULL_CNT);
endmodule

// File: tb/tb_ok_pipe_out_buf.sv
// Directed self-checking bench for ok_pipe_out_buf (DEPTH=16, ADDR=8'hA0).
// Status-bit expectations follow OK_PIPEOUT_STATUS_EN if it is defined for the build.
module tb_ok_pipe_out_buf;
    localparam int DEPTH = 16;
`ifdef OK_PIPEOUT_STATUS_EN
    localparam logic STAT = 1'b1;
`else
    localparam logic STAT = 1'b0;
`endif

    logic okClk = 1'b0;
    logic okRst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 okClk = ~okClk;

    ok_pipe_out_buf_if #(.DEPTH(DEPTH)) bus ();

    ok_pipe_out_buf #(.ADDR(8'hA0), .DEPTH(DEPTH)) dut (
        .okClk   (okClk),
        .okRst_n (okRst_n),
        .bus     (bus.slave)
    );

    function automatic logic [64:0] mk_eh(logic [10:0] cnt, logic rdy, logic vld,
                                          logic [31:0] d, logic [1:0] st);
        return {18'h0, st, cnt, rdy, vld, d};
    endfunction

    task automatic tick;
        @(posedge okClk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.hi_addr   = 8'h00;
        bus.hi_read   = 1'b0;
        bus.hi_clear  = 1'b0;
        bus.ep_write  = 1'b0;
        bus.ep_datain = 32'h0;
    endtask

    task automatic test_reset;
        okRst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.hi_addr   = (i == 1) ? 8'hA0 : 8'($urandom);
            bus.hi_read   = 1'b1;
            bus.hi_clear  = 1'($urandom);
            bus.ep_write  = 1'b1;
            bus.ep_datain = $urandom;
            tick;
            vectors++;
            if (bus.okEH !== 65'h0 || bus.ep_count !== 5'd0 || bus.ep_full !== 1'b0) begin
                miscompares++;
                $display("FAIL reset[%0d]: okEH=%h count=%0d full=%b, want 0/0/0",
                         i, bus.okEH, bus.ep_count, bus.ep_full);
            end
        end
        idle_inputs();
        okRst_n = 1'b1;
        tick;
    endtask

    task automatic test_ordering;
        logic [31:0] words [3];
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            bus.ep_write  = 1'b1;
            bus.ep_datain = words[i];
            tick;
        end
        bus.ep_write = 1'b0;
        vectors++;
        if (bus.ep_count !== 5'd3 || bus.okEH !== 65'h0) begin
            miscompares++;
            $display("FAIL order_fill: count=%0d okEH=%h, want 3 and 0", bus.ep_count, bus.okEH);
        end
        bus.hi_addr = 8'hA0;
        bus.hi_read = 1'b1;
        tick;
        vectors++;
        if (bus.ep_count !== 5'd2 || bus.okEH[32] !== 1'b0) begin
            miscompares++;
            $display("FAIL order_pop1: count=%0d valid=%b, want 2 and 0", bus.ep_count, bus.okEH[32]);
        end
        tick;
        vectors++;
        if (bus.ep_count !== 5'd1 || bus.okEH !== mk_eh(11'd2, 1'b1, 1'b1, words[0], 2'b00)) begin
            miscompares++;
            $display("FAIL order_word0: count=%0d okEH=%h, want 1 and %h",
                     bus.ep_count, bus.okEH, mk_eh(11'd2, 1'b1, 1'b1, words[0], 2'b00));
        end
        tick;
        vectors++;
        if (bus.ep_count !== 5'd0 || bus.okEH !== mk_eh(11'd1, 1'b1, 1'b1, words[1], 2'b00)) begin
            miscompares++;
            $display("FAIL order_word1: count=%0d okEH=%h, want 0 and %h",
                     bus.ep_count, bus.okEH, mk_eh(11'd1, 1'b1, 1'b1, words[1], 2'b00));
        end
        bus.hi_read = 1'b0;
        tick;
        vectors++;
        if (bus.okEH !== mk_eh(11'd0, 1'b0, 1'b1, words[2], 2'b00)) begin
            miscompares++;
            $display("FAIL order_word2: okEH=%h, want %h",
                     bus.okEH, mk_eh(11'd0, 1'b0, 1'b1, words[2], 2'b00));
        end
        tick;
        vectors++;
        if (bus.okEH[32] !== 1'b0) begin
            miscompares++;
            $display("FAIL order_end: valid=%b, want 0", bus.okEH[32]);
        end
        idle_inputs();
    endtask

    task automatic test_full;
        for (int i = 0; i <= 16; i++) begin
            bus.ep_write  = 1'b1;
            bus.ep_datain = 32'(i);
            tick;
            if (i == 14 || i == 15) begin
                vectors++;
                if (bus.ep_full !== (i == 15) || bus.ep_count !== 5'(i + 1)) begin
                    miscompares++;
                    $display("FAIL full_push%0d: full=%b count=%0d, want %b and %0d",
                             i, bus.ep_full, bus.ep_count, (i == 15), i + 1);
                end
            end
        end
        bus.ep_write = 1'b0;
        vectors++;
        if (bus.ep_full !== 1'b1 || bus.ep_count !== 5'd16) begin
            miscompares++;
            $display("FAIL full_drop: full=%b count=%0d, want 1 and 16", bus.ep_full, bus.ep_count);
        end
        bus.hi_addr = 8'hA0;
        tick;
        vectors++;
        if (bus.okEH !== mk_eh(11'd16, 1'b1, 1'b0, 32'h0, {1'b0, STAT})) begin
            miscompares++;
            $display("FAIL full_status: okEH=%h, want %h",
                     bus.okEH, mk_eh(11'd16, 1'b1, 1'b0, 32'h0, {1'b0, STAT}));
        end
    endtask

    task automatic test_full_boundary;
        logic [31:0] expq [17];
        for (int i = 0; i < 16; i++) expq[i] = 32'(i);
        expq[16] = 32'hAAAA5555;
        bus.hi_addr   = 8'hA0;
        bus.hi_read   = 1'b1;
        bus.ep_write  = 1'b1;
        bus.ep_datain = 32'hAAAA5555;
        tick;
        bus.ep_write = 1'b0;
        vectors++;
        if (bus.ep_count !== 5'd16 || bus.ep_full !== 1'b1) begin
            miscompares++;
            $display("FAIL bound_count: count=%0d full=%b, want 16 and 1", bus.ep_count, bus.ep_full);
        end
        for (int i = 0; i < 17; i++) begin
            if (i == 16) bus.hi_read = 1'b0;
            tick;
            vectors++;
            if (bus.okEH[32:0] !== {1'b1, expq[i]}) begin
                miscompares++;
                $display("FAIL bound_word%0d: got %h, want %h", i, bus.okEH[32:0], {1'b1, expq[i]});
            end
        end
        tick;
        vectors++;
        if (bus.okEH[32] !== 1'b0 || bus.ep_count !== 5'd0) begin
            miscompares++;
            $display("FAIL bound_drained: valid=%b count=%0d, want 0 and 0", bus.okEH[32], bus.ep_count);
        end
        idle_inputs();
    endtask

    task automatic test_underflow_isolation;
        bus.hi_addr   = 8'hA0;
        bus.hi_read   = 1'b1;
        bus.ep_write  = 1'b1;
        bus.ep_datain = 32'h5A5A5A5A;
        tick;
        bus.hi_read  = 1'b0;
        bus.ep_write = 1'b0;
        vectors++;
        if (bus.ep_count !== 5'd1) begin
            miscompares++;
            $display("FAIL unf_push: count=%0d, want 1", bus.ep_count);
        end
        tick;
        vectors++;
        if (bus.okEH !== mk_eh(11'd1, 1'b1, 1'b0, 32'h0, {STAT, STAT})) begin
            miscompares++;
            $display("FAIL unf_status: okEH=%h, want %h",
                     bus.okEH, mk_eh(11'd1, 1'b1, 1'b0, 32'h0, {STAT, STAT}));
        end
        bus.hi_clear = 1'b1;
        tick;
        bus.hi_clear = 1'b0;
        tick;
        vectors++;
        if (bus.okEH !== mk_eh(11'd1, 1'b1, 1'b0, 32'h0, 2'b00)) begin
            miscompares++;
            $display("FAIL clear: okEH=%h, want %h", bus.okEH, mk_eh(11'd1, 1'b1, 1'b0, 32'h0, 2'b00));
        end
        bus.hi_addr = 8'hA1;
        bus.hi_read = 1'b1;
        tick;
        tick;
        vectors++;
        if (bus.okEH !== 65'h0 || bus.ep_count !== 5'd1) begin
            miscompares++;
            $display("FAIL isolation: okEH=%h count=%0d, want 0 and 1", bus.okEH, bus.ep_count);
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < 5; i++) begin
            bus.ep_write  = 1'b1;
            bus.ep_datain = 32'hC0DE0000 + 32'(i);
            tick;
        end
        bus.ep_write = 1'b0;
        vectors++;
        if (bus.ep_count !== 5'd6) begin
            miscompares++;
            $display("FAIL mrst_fill: count=%0d, want 6", bus.ep_count);
        end
        bus.hi_addr = 8'hA0;
        bus.hi_read = 1'b1;
        tick;
        okRst_n = 1'b0;
        tick;
        vectors++;
        if (bus.okEH !== 65'h0 || bus.ep_count !== 5'd0) begin
            miscompares++;
            $display("FAIL mrst_hold: okEH=%h count=%0d, want 0 and 0", bus.okEH, bus.ep_count);
        end
        okRst_n     = 1'b1;
        bus.hi_read = 1'b0;
        tick;
        vectors++;
        if (bus.okEH !== 65'h0) begin
            miscompares++;
            $display("FAIL mrst_novalid: okEH=%h, want 0", bus.okEH);
        end
        bus.ep_write  = 1'b1;
        bus.ep_datain = 32'hBEEF0001;
        tick;
        bus.ep_write = 1'b0;
        bus.hi_read  = 1'b1;
        tick;
        bus.hi_read = 1'b0;
        tick;
        vectors++;
        if (bus.okEH[32:0] !== {1'b1, 32'hBEEF0001} || bus.ep_count !== 5'd0) begin
            miscompares++;
            $display("FAIL mrst_newdata: got %h count=%0d, want %h and 0",
                     bus.okEH[32:0], bus.ep_count, {1'b1, 32'hBEEF0001});
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_ordering();
        test_full();
        test_full_boundary();
        test_underflow_isolation();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
